// File: rtl/seq_multiplier_4bit.sv
// Unsigned 4x4 shift-and-add multiplier with a start/done handshake.
// One four_bit_adder forms the only add path; each RUN cycle adds and shifts once.

module four_bit_adder (
    input  logic [3:0] input_1,
    input  logic [3:0] input_2,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic [4:0] carry
);

    // Ripple chain: carry[0] is the incoming carry, carry[4] the carry-out.
    always_comb begin
        logic [4:0] c;
        c    = '0;
        sum  = '0;
        c[0] = c_in;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = input_1[i] ^ input_2[i] ^ c[i];
            c[i + 1] = (input_1[i] & input_2[i]) | (c[i] & (input_1[i] ^ input_2[i]));
        end
        carry = c;
    end

endmodule

module seq_multiplier_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] input_1,
    input  logic [3:0] input_2,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [3:0] a;
    logic [3:0] acc;
    logic [3:0] q;
    logic [1:0] cnt;

    logic [3:0] addend;
    logic [3:0] sum;
    logic [4:0] carry;
    logic       c;
    logic       unused_carry;

    assign addend       = q[0] ? a : 4'b0000;
    assign c            = carry[4];
    assign unused_carry = ^carry[3:0];

    four_bit_adder adder (
        .input_1 (acc),
        .input_2 (addend),
        .c_in    (1'b0),
        .sum     (sum),
        .carry   (carry)
    );

    // Next state and status flags, decoded purely from the registered state.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == 2'd3) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The carry-out becomes the new ACC MSB, so {ACC,Q} shifts right as one 9-bit value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a       <= '0;
            acc     <= '0;
            q       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        a   <= input_1;
                        q   <= input_2;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    acc <= {c, sum[3:1]};
                    q   <= {sum[0], q[3:1]};
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        product <= {c, sum[3:1], sum[0], q[3:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_4bit.sv
// Directed testbench for seq_multiplier_4bit: handshake timing, ignored starts,
// mid-run reset, back-to-back starts and a full 16x16 operand sweep.

module tb_seq_multiplier_4bit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] input_1;
    logic [3:0] input_2;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int checkCount;
    int errorCount;
    int doneCount;
    int doneBase;

    seq_multiplier_4bit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .input_1 (input_1),
        .input_2 (input_2),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) begin
            doneCount = doneCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (actual !== expected) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Bounded wait until done is seen at a negedge sample.
    task automatic waitDone(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                break;
            end
            @(negedge clk);
        end
        checkOutput({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    // One full transaction from IDLE with cycle-exact handshake checks.
    task automatic applyStimulus(input logic [3:0] x, input logic [3:0] y,
                                 input logic [7:0] expected, input string tag);
        @(negedge clk);
        input_1 = x;
        input_2 = y;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        input_1 = ~x;
        input_2 = ~y;
        for (int k = 0; k < 4; k++) begin
            checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
            checkOutput({tag, "_nodone"}, {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
        checkOutput({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_product"}, {24'd0, product}, {24'd0, expected});
        @(negedge clk);
        checkOutput({tag, "_idle_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        doneCount  = 0;
        rst        = 1'b1;
        start      = 1'b0;
        input_1    = 4'd0;
        input_2    = 4'd0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_product", {24'd0, product}, 32'd0);
        rst = 1'b0;

        // Largest operands, then product must hold
        applyStimulus(4'd15, 4'd15, 8'hE1, "mul_15x15");
        repeat (3) @(negedge clk);
        checkOutput("hold_E1", {24'd0, product}, 32'hE1);

        applyStimulus(4'd13, 4'd11, 8'h8F, "mul_13x11");
        applyStimulus(4'd9, 4'd0, 8'h00, "mul_9x0");

        // start pulses during RUN cycles 2 and 4 and during DONE are ignored
        $display("[TB] ignored-start test");
        doneBase = doneCount;
        @(negedge clk);
        input_1 = 4'd6;
        input_2 = 4'd7;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        input_1 = 4'd15;
        input_2 = 4'd15;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        checkOutput("ign_done", {31'd0, done}, 32'd1);
        checkOutput("ign_product", {24'd0, product}, 32'h2A);
        @(negedge clk);
        start = 1'b0;
        checkOutput("ign_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("ign_idle_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("ign_no_restart", {31'd0, busy}, 32'd0);
        checkOutput("ign_done_count", doneCount - doneBase, 32'd1);
        checkOutput("ign_product_hold", {24'd0, product}, 32'h2A);

        // Reset in the 2nd RUN cycle abandons the operation
        $display("[TB] mid-run reset test");
        doneBase = doneCount;
        @(negedge clk);
        input_1 = 4'd15;
        input_2 = 4'd15;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_product", {24'd0, product}, 32'h00);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("rst_no_done", doneCount - doneBase, 32'd0);
        applyStimulus(4'd3, 4'd5, 8'h0F, "mul_3x5");

        // start held high: each return to IDLE re-accepts on the next edge
        $display("[TB] held-start test");
        doneBase = doneCount;
        @(negedge clk);
        input_1 = 4'd5;
        input_2 = 4'd5;
        start   = 1'b1;
        for (int r = 0; r < 3; r++) begin
            waitDone("held");
            checkOutput("held_product", {24'd0, product}, 32'h19);
            @(negedge clk);
            checkOutput("held_idle_busy", {31'd0, busy}, 32'd0);
            checkOutput("held_idle_done", {31'd0, done}, 32'd0);
            @(negedge clk);
            checkOutput("held_reaccept", {31'd0, busy}, 32'd1);
        end
        start = 1'b0;
        waitDone("held_last");
        checkOutput("held_last_product", {24'd0, product}, 32'h19);
        @(negedge clk);
        checkOutput("held_done_count", doneCount - doneBase, 32'd4);

        // Full operand sweep against the arithmetic reference
        $display("[TB] exhaustive sweep");
        doneBase = doneCount;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                applyStimulus(4'(i), 4'(j), 8'(i * j), "sweep");
            end
        end
        checkOutput("sweep_done_count", doneCount - doneBase, 32'd256);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
